// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among R requesters.
// The owner's operands are steered to the adder; sum and carry are broadcast back.
module adder_arbiter #(
    parameter int unsigned N = 8,
    parameter int unsigned R = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [R-1:0]         i_request,
    input  logic [R*N-1:0]       i_augend,
    input  logic [R*N-1:0]       i_addend,
    output logic [R-1:0]         o_grant,
    output logic [N-1:0]         o_sum,
    output logic                 o_carry,
    output logic                 o_busy,
    output logic [$clog2(R)-1:0] o_owner,
    output logic [N-1:0]         o_adder_augend,
    output logic [N-1:0]         o_adder_addend,
    input  logic [N-1:0]         i_adder_sum,
    input  logic                 i_adder_carry
);

    localparam int unsigned OW = $clog2(R);

    typedef enum logic {StIdle, StOwned} state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [R-1:0]    grant_q, grant_d;

    logic            found;
    logic [OW-1:0]   pick;
    logic [OW-1:0]   idx;

    // Search upward from last+1 (mod R); the first requester found wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 1; i <= R; i++) begin
            idx = OW'((32'(last_q) + i) % R);
            if (!found && i_request[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (state_q == StOwned && i_request[owner_q]) begin
            state_d = StOwned;
        end else if (found) begin
            state_d = StOwned;
            owner_d = pick;
            last_d  = pick;
        end else begin
            state_d = StIdle;
            owner_d = '0;
        end
        grant_d = (state_d == StOwned) ? (R'(1) << owner_d) : '0;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= OW'(R - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    // Only the owner's slices ever reach the adder; idle drives zeros.
    always_comb begin
        o_adder_augend = '0;
        o_adder_addend = '0;
        for (int unsigned k = 0; k < R; k++) begin
            if (state_q == StOwned && owner_q == OW'(k)) begin
                o_adder_augend = i_augend[k*N +: N];
                o_adder_addend = i_addend[k*N +: N];
            end
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q == StOwned);
    assign o_owner = owner_q;
    assign o_sum   = i_adder_sum;
    assign o_carry = i_adder_carry;

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one combinational Adder between several sequential arithmetic units (multiplier, divider, future ALU ops) that each drive an external adder through augend/addend/sum ports. The block accepts per-requester request/operand buses, grants the adder to exactly one requester at a time using round-robin arbitration, and holds the grant while the owner keeps its request high. It sits between the arithmetic units and a single `Adder #(.N(N))` instance in the top level.

## Interface
- `N`, default 8: adder width, equal to the instantiated Adder's N.
- `R`, default 2: number of requesters, valid range 2–8.
- `i_clock`  in  1  system clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_request`  in  R  bit k high: requester k wants the adder.
- `i_augend`  in  R*N  packed augends; requester k occupies bits [k*N +: N].
- `i_addend`  in  R*N  packed addends, same packing.
- `o_grant`  out  R  one-hot or zero; bit k high: requester k owns the adder this cycle.
- `o_sum`  out  N  adder sum, broadcast to all requesters.
- `o_carry`  out  1  adder carry, broadcast.
- `o_busy`  out  1  high when any grant is active.
- `o_owner`  out  clog2(R)  index of current owner; 0 when idle.
- `o_adder_augend`  out  N  to external Adder `i_augend`.
- `o_adder_addend`  out  N  to external Adder `i_addend`.
- `i_adder_sum`  in  N  from external Adder `o_sum`.
- `i_adder_carry`  in  1  from external Adder `o_carry`.

## Operation
- Two states: IDLE (no owner) and OWNED (owner index registered).
- IDLE: at each edge, if any `i_request` bit is high, grant the first requesting index found searching upward from `last + 1` mod R, where `last` is the previous owner. Then set `last` to that index and go to OWNED. If no request is high, stay in IDLE.
- OWNED: if `i_request[owner]` is still high at the edge, keep the grant; there is no timeout and no preemption.
- OWNED with the owner's request low at the edge: re-arbitrate in the same edge using the same round-robin rule. The old owner's bit is low, so it is excluded. If another requester is waiting, ownership passes directly with no idle cycle; otherwise go to IDLE.
- Datapath is combinational from registered state:
  - `o_adder_augend`/`o_adder_addend` equal the owner's N-bit slices while OWNED, and all zeros in IDLE.
  - `o_sum = i_adder_sum`, `o_carry = i_adder_carry`, unregistered.
  - Only the granted requester may consume `o_sum`.
- Arithmetic is N-bit modulo; carry out reports overflow. The block never alters operands.
- Request bits for indices not granted are ignored. Operand values of non-owners never reach the adder.
- Reset:
  - Asynchronously forces IDLE, `o_grant = 0`, `o_busy = 0`, `o_owner = 0`, and zero adder operands.
  - Sets `last = R-1`, so requester 0 has first priority after reset.
  - A reset mid-ownership drops the grant immediately, without waiting for a clock edge.

## Timing
- Request-to-grant latency is 1 cycle from a free adder: request high before edge t gives `o_grant` high after edge t.
- Sum latency is 0 cycles after grant: operands presented in a granted cycle give a valid `o_sum` in that same cycle.
- Release-to-handoff:
  - Owner deasserts request before edge t; at edge t the grant moves to the next waiting requester.
  - The new owner's operands reach the adder in the cycle after edge t.
- Requester contract: hold request high for every cycle the adder is used, and drop it in the cycle after the last use.
- Worst-case wait for requester k is the sum of the other R-1 owners' hold durations plus 1 cycle.
- `o_grant`, `o_busy` and `o_owner` are registered outputs and glitch-free.

## Test plan
- Reset and single request:
  - Assert then release reset; `o_grant = 0`, `o_busy = 0`, adder operands 0.
  - Raise `i_request = 2'b10` with augend1 = 8'h25, addend1 = 8'h13.
  - After 1 edge, `o_grant = 2'b10`, `o_owner = 1`, `o_sum = 8'h38`, `o_carry = 0`.
- Overflow passthrough: owner 0 presents 8'hF0 + 8'h20 → `o_sum = 8'h10`, `o_carry = 1`.
- Simultaneous requests after reset:
  - `i_request = 2'b11` → grant 0 first.
  - Drop request 0 → grant 1 at the next edge, no idle cycle.
  - Requester 0 re-requests while 1 holds → waits until 1 releases, then gets the grant.
- Round-robin fairness with R = 4:
  - All four requests held, each owner releasing after 3 cycles.
  - Grant order is 0, 1, 2, 3, 0, each with 3-cycle ownership and no gaps.
- Non-owner isolation: while requester 0 owns with 8'h01 + 8'h01, requester 1 toggles its operands every cycle → `o_adder_augend` stays 8'h01 and `o_sum` stays 8'h02.
- Reset mid-ownership: assert `i_reset` asynchronously between edges while owner 1 is active → `o_grant = 0` immediately. After release with `i_request = 2'b11`, grant goes to 0 first.
